serv_pc_seq: RTL and testbench
==============================

SERV_PC_SEQ -- requirements
Module: serv_pc_seq

Interface
REQ-001 SHALL have parameter W, default 1: datapath width per cycle; legal values 1 and 4.
REQ-002 SHALL have parameter WITH_CSR, default 1: when 0, trap logic is removed and o_trap is tied to 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port i_ibus_ack, input, 1 bit: instruction fetch acknowledged; decode inputs are valid in the same cycle.
REQ-006 SHALL have port i_two_stage, input, 1 bit: instruction needs a compare stage before the PC update.
REQ-007 SHALL have port i_cond_branch, input, 1 bit: instruction is a conditional branch.
REQ-008 SHALL have port i_jal_or_jalr, input, 1 bit: instruction is an unconditional jump.
REQ-009 SHALL have port i_alu_cmp, input, 1 bit: branch compare result, valid on the last compare-stage cycle.
REQ-010 SHALL have port i_trap_req, input, 1 bit: trap request.
REQ-011 SHALL have port o_ibus_cyc, output, 1 bit: fetch request.
REQ-012 SHALL have port o_pc_en, output, 1 bit: PC shift enable.
REQ-013 SHALL have ports o_cnt0, o_cnt1, o_cnt2, o_cnt12to15 and o_cnt16to31, outputs, 1 bit each: bit-position strobes.
REQ-014 SHALL have port o_cnt_done, output, 1 bit: last chunk of a stage.
REQ-015 SHALL have port o_jump, output, 1 bit: select branch/jump target.
REQ-016 SHALL have port o_trap, output, 1 bit: select trap vector.
REQ-017 SHALL have port o_busy, output, 1 bit: stage in progress (state INIT or RUN).

Function
REQ-018 SHALL implement states RST_WAIT, FETCH, INIT and RUN.
REQ-019 SHALL move RST_WAIT -> FETCH unconditionally one cycle after reset release.
REQ-020 In FETCH, SHALL assert o_ibus_cyc=1 and hold it until i_ibus_ack.
REQ-021 In FETCH with i_ibus_ack=1, SHALL go to RUN if i_trap_req=1 (and WITH_CSR=1), else to INIT if i_two_stage=1, else to RUN.
REQ-022 SHALL ignore i_ibus_ack in every state other than FETCH.
REQ-023 SHALL keep a 5-bit counter cnt holding the LSB bit index of the current chunk; cnt is 0 on stage entry, advances by W each INIT/RUN cycle, and wraps 32-W -> 0.
REQ-024 For W=1: o_cnt0, o_cnt1 and o_cnt2 SHALL assert at cnt=0, 1 and 2 respectively.
REQ-025 For W=4: o_cnt0, o_cnt1 and o_cnt2 SHALL all assert together at cnt=0.
REQ-026 o_cnt12to15 SHALL assert for cnt in 12..15; o_cnt16to31 SHALL assert for cnt >= 16.
REQ-027 o_cnt_done SHALL assert at cnt=32-W.
REQ-028 All o_cnt* strobes SHALL be 0 outside INIT and RUN.
REQ-029 Each stage (INIT or RUN) SHALL last exactly 32/W cycles.
REQ-030 INIT SHALL keep o_pc_en=0 and go to RUN after o_cnt_done.
REQ-031 RUN SHALL drive o_pc_en=1 on every cycle and go to FETCH after o_cnt_done; o_pc_en SHALL be 0 in all other states.
REQ-032 SHALL register jump at FETCH accept as i_jal_or_jalr.
REQ-033 SHALL OR into jump (i_cond_branch AND i_alu_cmp) sampled on the INIT o_cnt_done cycle.
REQ-034 o_jump SHALL be the registered jump value while in RUN, and 0 otherwise.
REQ-035 SHALL register trap as i_trap_req at FETCH accept, OR i_trap_req on the INIT o_cnt_done cycle.
REQ-036 o_trap SHALL be the registered trap value while in RUN, and 0 otherwise; o_trap=1 SHALL force o_jump=0.
REQ-037 SHALL clear the jump and trap registers on entry to FETCH.
REQ-038 i_trap_req and i_ibus_ack arriving in the same FETCH cycle SHALL take the trap path and skip INIT, even when i_two_stage=1.

Reset
REQ-039 While i_rst_n=0, SHALL immediately (asynchronously) force state=RST_WAIT, cnt=0, jump=0 and trap=0.
REQ-040 While i_rst_n=0, all outputs SHALL be 0.
REQ-041 Reset asserted mid-INIT or mid-RUN SHALL abort the stage; after release the block SHALL restart at RST_WAIT with no residual o_pc_en.

Verification
REQ-042 Scenario: W=1, reset release, ack in cycle 3, i_two_stage=0 -> o_ibus_cyc=1 from cycle 1; o_pc_en=1 for exactly 32 cycles; o_cnt0 on the first of them, o_cnt2 on the third; o_ibus_cyc=1 on the cycle after o_cnt_done.
REQ-043 Scenario: W=1, branch with i_two_stage=1, i_cond_branch=1, i_alu_cmp=1 at INIT done -> 32 cycles with o_pc_en=0, then 32 cycles with o_pc_en=1 and o_jump=1.
REQ-044 Scenario: same as REQ-043 with i_alu_cmp=0 -> o_jump=0 throughout RUN.
REQ-045 Scenario: W=4, i_jal_or_jalr=1 -> RUN lasts 8 cycles; o_cnt0, o_cnt1 and o_cnt2 together on the first cycle; o_cnt12to15 on the 4th; o_cnt16to31 on the 5th-8th; o_jump=1.
REQ-046 Scenario: i_trap_req=1 with ack and i_two_stage=1 -> INIT skipped; RUN with o_trap=1 and o_jump=0; repeat with WITH_CSR=0 -> INIT taken, o_trap=0.
REQ-047 Scenario: i_rst_n pulsed low at RUN cnt=17 -> all outputs 0 during reset; after release, 1 idle cycle, then o_ibus_cyc=1 and the next stage's counter starts at 0.

Source files
------------

// File: rtl/serv_pc_seq.sv
// Bit-serial PC sequencer: fetch handshake, optional compare stage,
// then a PC update stage, with jump/trap target selection.
module serv_pc_seq #(
  parameter int W        = 1,
  parameter int WITH_CSR = 1
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_ibus_ack,
  input  logic i_two_stage,
  input  logic i_cond_branch,
  input  logic i_jal_or_jalr,
  input  logic i_alu_cmp,
  input  logic i_trap_req,
  output logic o_ibus_cyc,
  output logic o_pc_en,
  output logic o_cnt0,
  output logic o_cnt1,
  output logic o_cnt2,
  output logic o_cnt12to15,
  output logic o_cnt16to31,
  output logic o_cnt_done,
  output logic o_jump,
  output logic o_trap,
  output logic o_busy
);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    FETCH    = 2'd1,
    INIT     = 2'd2,
    RUN      = 2'd3
  } state_t;

  localparam logic [4:0] STEP = 5'(W);
  localparam logic [4:0] LAST = 5'(32 - W);
  localparam logic [4:0] C1   = (W == 1) ? 5'd1 : 5'd0;
  localparam logic [4:0] C2   = (W == 1) ? 5'd2 : 5'd0;
  localparam logic       CSR  = (WITH_CSR != 0);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] cnt;
  logic       jump_q;
  logic       trap_q;
  logic       busy;
  logic       done;
  logic       accept;
  logic       trap_in;

  assign busy    = (state == INIT) || (state == RUN);
  assign done    = busy && (cnt == LAST);
  assign accept  = (state == FETCH) && i_ibus_ack;
  assign trap_in = CSR && i_trap_req;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RST_WAIT: state_nxt = FETCH;
      FETCH: begin
        if (i_ibus_ack) begin
          if (trap_in)          state_nxt = RUN;
          else if (i_two_stage) state_nxt = INIT;
          else                  state_nxt = RUN;
        end
      end
      INIT: if (done) state_nxt = RUN;
      RUN:  if (done) state_nxt = FETCH;
      default: state_nxt = RST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RST_WAIT;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      // wraps to 0 naturally after the last chunk
      if (busy) cnt <= cnt + STEP;
      else      cnt <= 5'd0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      jump_q <= 1'b0;
      trap_q <= 1'b0;
    end else if (accept) begin
      jump_q <= i_jal_or_jalr;
      trap_q <= trap_in;
    end else if ((state == INIT) && done) begin
      jump_q <= jump_q | (i_cond_branch & i_alu_cmp);
      trap_q <= trap_q | trap_in;
    end else if ((state_nxt == FETCH) && (state != FETCH)) begin
      jump_q <= 1'b0;
      trap_q <= 1'b0;
    end
  end

  assign o_ibus_cyc  = (state == FETCH);
  assign o_pc_en     = (state == RUN);
  assign o_busy      = busy;
  assign o_cnt0      = busy && (cnt == 5'd0);
  assign o_cnt1      = busy && (cnt == C1);
  assign o_cnt2      = busy && (cnt == C2);
  assign o_cnt12to15 = busy && (cnt[4:2] == 3'b011);
  assign o_cnt16to31 = busy && cnt[4];
  assign o_cnt_done  = done;
  assign o_trap      = (state == RUN) && CSR && trap_q;
  assign o_jump      = (state == RUN) && jump_q && !o_trap;

endmodule

// File: tb/tb_serv_pc_seq.sv
// Directed bench for serv_pc_seq: W=1, W=4 and trap-less variants
// share one stimulus stream; each step checks the relevant instance.
module tb_serv_pc_seq;

  localparam int IBUS = 10;
  localparam int PCEN = 9;
  localparam int C0   = 8;
  localparam int C1   = 7;
  localparam int C2   = 6;
  localparam int C12  = 5;
  localparam int C16  = 4;
  localparam int DONE = 3;
  localparam int JUMP = 2;
  localparam int TRAP = 1;
  localparam int BUSY = 0;

  logic clk = 1'b0;
  logic i_rst_n;
  logic i_ibus_ack;
  logic i_two_stage;
  logic i_cond_branch;
  logic i_jal_or_jalr;
  logic i_alu_cmp;
  logic i_trap_req;

  logic [10:0] o1;
  logic [10:0] o4;
  logic [10:0] o0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serv_pc_seq #(.W(1), .WITH_CSR(1)) u1 (
    .clk(clk), .i_rst_n(i_rst_n),
    .i_ibus_ack(i_ibus_ack), .i_two_stage(i_two_stage),
    .i_cond_branch(i_cond_branch), .i_jal_or_jalr(i_jal_or_jalr),
    .i_alu_cmp(i_alu_cmp), .i_trap_req(i_trap_req),
    .o_ibus_cyc(o1[IBUS]), .o_pc_en(o1[PCEN]),
    .o_cnt0(o1[C0]), .o_cnt1(o1[C1]), .o_cnt2(o1[C2]),
    .o_cnt12to15(o1[C12]), .o_cnt16to31(o1[C16]),
    .o_cnt_done(o1[DONE]), .o_jump(o1[JUMP]),
    .o_trap(o1[TRAP]), .o_busy(o1[BUSY])
  );

  serv_pc_seq #(.W(4), .WITH_CSR(1)) u4 (
    .clk(clk), .i_rst_n(i_rst_n),
    .i_ibus_ack(i_ibus_ack), .i_two_stage(i_two_stage),
    .i_cond_branch(i_cond_branch), .i_jal_or_jalr(i_jal_or_jalr),
    .i_alu_cmp(i_alu_cmp), .i_trap_req(i_trap_req),
    .o_ibus_cyc(o4[IBUS]), .o_pc_en(o4[PCEN]),
    .o_cnt0(o4[C0]), .o_cnt1(o4[C1]), .o_cnt2(o4[C2]),
    .o_cnt12to15(o4[C12]), .o_cnt16to31(o4[C16]),
    .o_cnt_done(o4[DONE]), .o_jump(o4[JUMP]),
    .o_trap(o4[TRAP]), .o_busy(o4[BUSY])
  );

  serv_pc_seq #(.W(1), .WITH_CSR(0)) u0 (
    .clk(clk), .i_rst_n(i_rst_n),
    .i_ibus_ack(i_ibus_ack), .i_two_stage(i_two_stage),
    .i_cond_branch(i_cond_branch), .i_jal_or_jalr(i_jal_or_jalr),
    .i_alu_cmp(i_alu_cmp), .i_trap_req(i_trap_req),
    .o_ibus_cyc(o0[IBUS]), .o_pc_en(o0[PCEN]),
    .o_cnt0(o0[C0]), .o_cnt1(o0[C1]), .o_cnt2(o0[C2]),
    .o_cnt12to15(o0[C12]), .o_cnt16to31(o0[C16]),
    .o_cnt_done(o0[DONE]), .o_jump(o0[JUMP]),
    .o_trap(o0[TRAP]), .o_busy(o0[BUSY])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    i_ibus_ack    = 1'b0;
    i_two_stage   = 1'b0;
    i_cond_branch = 1'b0;
    i_jal_or_jalr = 1'b0;
    i_alu_cmp     = 1'b0;
    i_trap_req    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_u1"}, 32'(o1), 32'd0);
    chk({tag, "_u4"}, 32'(o4), 32'd0);
    chk({tag, "_u0"}, 32'(o0), 32'd0);
  endtask

  task automatic do_reset;
    i_rst_n = 1'b0;
    clr_in();
    #1;
    chk_all_zero("rst_now");
    tick();
    chk_all_zero("rst_hold");
    i_rst_n = 1'b1;
  endtask

  task automatic branch(input logic cmp, input string t);
    do_reset();
    tick();
    chk({t, "_fetch"}, 32'(o1[IBUS]), 32'd1);
    i_ibus_ack    = 1'b1;
    i_two_stage   = 1'b1;
    i_cond_branch = 1'b1;
    tick();
    i_ibus_ack  = 1'b0;
    i_two_stage = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s_init_pc_%0d", t, i), 32'(o1[PCEN]), 32'd0);
      chk($sformatf("%s_init_busy_%0d", t, i), 32'(o1[BUSY]), 32'd1);
      chk($sformatf("%s_init_done_%0d", t, i), 32'(o1[DONE]),
          32'(i == 31));
      chk($sformatf("%s_init_jmp_%0d", t, i), 32'(o1[JUMP]), 32'd0);
      if (i == 31) i_alu_cmp = cmp;
      tick();
    end
    i_alu_cmp     = 1'b0;
    i_cond_branch = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s_run_pc_%0d", t, i), 32'(o1[PCEN]), 32'd1);
      chk($sformatf("%s_run_jmp_%0d", t, i), 32'(o1[JUMP]), 32'(cmp));
      tick();
    end
    chk({t, "_refetch"}, 32'(o1[IBUS]), 32'd1);
    chk({t, "_jmp_clr"}, 32'(o1[JUMP]), 32'd0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    clr_in();

    // W=1 straight-line instruction
    do_reset();
    chk("a_cyc0", 32'(o1[IBUS]), 32'd0);
    tick();
    chk("a_cyc1", 32'(o1[IBUS]), 32'd1);
    tick();
    chk("a_cyc2", 32'(o1[IBUS]), 32'd1);
    tick();
    chk("a_cyc3", 32'(o1[IBUS]), 32'd1);
    chk("a_cyc3_pc", 32'(o1[PCEN]), 32'd0);
    i_ibus_ack = 1'b1;
    tick();
    i_ibus_ack = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("a_pc_%0d", i), 32'(o1[PCEN]), 32'd1);
      chk($sformatf("a_cyc_%0d", i), 32'(o1[IBUS]), 32'd0);
      chk($sformatf("a_c0_%0d", i), 32'(o1[C0]), 32'(i == 0));
      chk($sformatf("a_c1_%0d", i), 32'(o1[C1]), 32'(i == 1));
      chk($sformatf("a_c2_%0d", i), 32'(o1[C2]), 32'(i == 2));
      chk($sformatf("a_c12_%0d", i), 32'(o1[C12]),
          32'(i >= 12 && i <= 15));
      chk($sformatf("a_c16_%0d", i), 32'(o1[C16]), 32'(i >= 16));
      chk($sformatf("a_done_%0d", i), 32'(o1[DONE]), 32'(i == 31));
      chk($sformatf("a_jmp_%0d", i), 32'(o1[JUMP]), 32'd0);
      i_ibus_ack = (i == 5);
      tick();
    end
    i_ibus_ack = 1'b0;
    chk("a_refetch", 32'(o1[IBUS]), 32'd1);
    chk("a_idle_pc", 32'(o1[PCEN]), 32'd0);
    chk("a_idle_c0", 32'(o1[C0]), 32'd0);
    tick();
    chk("a_hold_cyc", 32'(o1[IBUS]), 32'd1);

    // taken and not-taken conditional branches
    branch(1'b1, "b");
    branch(1'b0, "c");

    // W=4 jump
    do_reset();
    tick();
    chk("d_fetch", 32'(o4[IBUS]), 32'd1);
    i_ibus_ack    = 1'b1;
    i_jal_or_jalr = 1'b1;
    tick();
    clr_in();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("d_pc_%0d", i), 32'(o4[PCEN]), 32'd1);
      chk($sformatf("d_c0_%0d", i), 32'(o4[C0]), 32'(i == 0));
      chk($sformatf("d_c1_%0d", i), 32'(o4[C1]), 32'(i == 0));
      chk($sformatf("d_c2_%0d", i), 32'(o4[C2]), 32'(i == 0));
      chk($sformatf("d_c12_%0d", i), 32'(o4[C12]), 32'(i == 3));
      chk($sformatf("d_c16_%0d", i), 32'(o4[C16]), 32'(i >= 4));
      chk($sformatf("d_done_%0d", i), 32'(o4[DONE]), 32'(i == 7));
      chk($sformatf("d_jmp_%0d", i), 32'(o4[JUMP]), 32'd1);
      tick();
    end
    chk("d_refetch", 32'(o4[IBUS]), 32'd1);
    chk("d_idle_pc", 32'(o4[PCEN]), 32'd0);
    chk("d_jmp_clr", 32'(o4[JUMP]), 32'd0);

    // trap with ack skips INIT; trap-less build takes INIT
    do_reset();
    tick();
    i_ibus_ack    = 1'b1;
    i_trap_req    = 1'b1;
    i_two_stage   = 1'b1;
    i_jal_or_jalr = 1'b1;
    tick();
    clr_in();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("e_pc_%0d", i), 32'(o1[PCEN]), 32'd1);
      chk($sformatf("e_trap_%0d", i), 32'(o1[TRAP]), 32'd1);
      chk($sformatf("e_jmp_%0d", i), 32'(o1[JUMP]), 32'd0);
      chk($sformatf("e0_pc_%0d", i), 32'(o0[PCEN]), 32'd0);
      chk($sformatf("e0_busy_%0d", i), 32'(o0[BUSY]), 32'd1);
      chk($sformatf("e0_trap_%0d", i), 32'(o0[TRAP]), 32'd0);
      tick();
    end
    chk("e_refetch", 32'(o1[IBUS]), 32'd1);
    chk("e_trap_clr", 32'(o1[TRAP]), 32'd0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("e0_rpc_%0d", i), 32'(o0[PCEN]), 32'd1);
      chk($sformatf("e0_rtrap_%0d", i), 32'(o0[TRAP]), 32'd0);
      chk($sformatf("e0_rjmp_%0d", i), 32'(o0[JUMP]), 32'd1);
      tick();
    end
    chk("e0_refetch", 32'(o0[IBUS]), 32'd1);

    // reset pulse in the middle of RUN
    do_reset();
    tick();
    i_ibus_ack = 1'b1;
    tick();
    i_ibus_ack = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk("f_cnt17_c16", 32'(o1[C16]), 32'd1);
    chk("f_cnt17_pc", 32'(o1[PCEN]), 32'd1);
    chk("f_cnt17_done", 32'(o1[DONE]), 32'd0);
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("f_rst_now");
    tick();
    chk_all_zero("f_rst_hold");
    i_rst_n = 1'b1;
    chk("f_idle_cyc", 32'(o1[IBUS]), 32'd0);
    chk("f_idle_pc", 32'(o1[PCEN]), 32'd0);
    tick();
    chk("f_fetch", 32'(o1[IBUS]), 32'd1);
    chk("f_fetch_pc", 32'(o1[PCEN]), 32'd0);
    i_ibus_ack = 1'b1;
    tick();
    i_ibus_ack = 1'b0;
    chk("f_run_pc", 32'(o1[PCEN]), 32'd1);
    chk("f_run_c0", 32'(o1[C0]), 32'd1);
    tick();
    chk("f_run_c1", 32'(o1[C1]), 32'd1);
    chk("f_run_c0b", 32'(o1[C0]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
